// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: snapshots an N-digit hex bus once per frame
// and scans it onto a shared segment bus with blanking, zero suppression and a frame pulse.
module seg_scan_driver #(
  parameter int FREQUENCY_IN   = 50_000_000,
  parameter int SCAN_FREQ      = 1000,
  parameter int DIGIT_NUM      = 8,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic [DIGIT_NUM*4-1:0] bcd_in,
  input  logic [DIGIT_NUM-1:0]   dp_in,
  input  logic                   lz_en_in,
  output logic [7:0]             seg_out,
  output logic [DIGIT_NUM-1:0]   dig_out,
  output logic                   frame_done_out
);

  localparam int DIV   = FREQUENCY_IN / SCAN_FREQ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]     BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DIGIT_NUM - 1);
  localparam logic [7:0]           SEG_INACT = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGIT_NUM-1:0] DIG_INACT = (DIG_ACTIVE_LOW != 0) ? {DIGIT_NUM{1'b1}}
                                                                     : {DIGIT_NUM{1'b0}};

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      4'hF:    g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DIGIT_NUM*4-1:0] sh_bcd_q;
  logic [DIGIT_NUM-1:0]   sh_dp_q;
  logic [7:0]             seg_q;
  logic [DIGIT_NUM-1:0]   dig_q;
  logic                   fd_q;

  logic                   snap_s;
  logic                   wrap_s;
  logic [DIGIT_NUM*4-1:0] bcd_s;
  logic [DIGIT_NUM-1:0]   dp_s;
  logic [3:0]             nib_s;
  logic                   dpbit_s;
  logic                   hide_s;
  logic [DIGIT_NUM-1:0]   onehot_s;
  logic [7:0]             seg_raw_s;
  logic [DIGIT_NUM-1:0]   dig_raw_s;

  // The snapshot clock itself already displays the freshly captured frame.
  assign snap_s = en_in && (cnt_q == {CNT_W{1'b0}}) && (idx_q == {IDX_W{1'b0}});
  assign bcd_s  = snap_s ? bcd_in : sh_bcd_q;
  assign dp_s   = snap_s ? dp_in  : sh_dp_q;

  // Slot counter and digit index sequencing, frame wrap detection.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wrap_s = 1'b0;
    if (!en_in) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = {IDX_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d  = {IDX_W{1'b0}};
        wrap_s = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Select the active digit; upper_zero tracks "all digits from the top down to i are 0".
  always_comb begin
    logic upper_zero;
    logic sel;
    nib_s      = 4'h0;
    dpbit_s    = 1'b0;
    hide_s     = 1'b0;
    onehot_s   = {DIGIT_NUM{1'b0}};
    upper_zero = 1'b1;
    sel        = 1'b0;
    for (int i = DIGIT_NUM - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (bcd_s[4*i +: 4] == 4'h0);
      sel         = (idx_q == IDX_W'(i));
      nib_s       = nib_s | (bcd_s[4*i +: 4] & {4{sel}});
      dpbit_s     = dpbit_s | (dp_s[i] & sel);
      onehot_s[i] = sel;
      hide_s      = hide_s | (sel & lz_en_in & upper_zero & (i != 0));
    end
  end

  // Active-high segment/digit pattern before polarity.
  always_comb begin
    seg_raw_s = 8'h00;
    dig_raw_s = {DIGIT_NUM{1'b0}};
    if (!en_in || (cnt_q < BLANK_END)) begin
      seg_raw_s = 8'h00;
      dig_raw_s = {DIGIT_NUM{1'b0}};
    end else begin
      seg_raw_s = {dpbit_s, (hide_s ? 7'h00 : glyph(nib_s))};
      dig_raw_s = onehot_s;
    end
  end

  // State, shadow capture and polarity-applied output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      sh_bcd_q <= {(DIGIT_NUM*4){1'b0}};
      sh_dp_q  <= {DIGIT_NUM{1'b0}};
      seg_q    <= SEG_INACT;
      dig_q    <= DIG_INACT;
      fd_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      fd_q  <= wrap_s;
      seg_q <= seg_raw_s ^ SEG_INACT;
      dig_q <= dig_raw_s ^ DIG_INACT;
      if (snap_s) begin
        sh_bcd_q <= bcd_in;
        sh_dp_q  <= dp_in;
      end else begin
        sh_bcd_q <= sh_bcd_q;
        sh_dp_q  <= sh_dp_q;
      end
    end
  end

  assign seg_out        = seg_q;
  assign dig_out        = dig_q;
  assign frame_done_out = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a time-index reference model.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int N     = 8;
  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = DIV * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_in = 1'b0;
  logic        lz_en_in = 1'b0;
  logic [31:0] bcd_in = 32'h0;
  logic [7:0]  dp_in = 8'h0;
  logic [7:0]  seg_out;
  logic [7:0]  dig_out;
  logic        frame_done_out;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .FREQUENCY_IN(1000), .SCAN_FREQ(100), .DIGIT_NUM(8),
    .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .bcd_in(bcd_in), .dp_in(dp_in),
    .lz_en_in(lz_en_in), .seg_out(seg_out), .dig_out(dig_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: t counts enabled clocks since (re)start; slot, digit and frame follow by arithmetic.
  int          t = 0;
  int          last_t = -1;
  logic [31:0] m_bcd = 32'h0;
  logic [7:0]  m_dp = 8'h0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [7:0]  exp_dig = 8'hFF;
  logic        exp_fd = 1'b0;

  always @(posedge clk or negedge rst) begin
    int d;
    logic [3:0] nib;
    logic lead;
    if (!rst) begin
      t = 0; last_t = -1; m_bcd = 32'h0; m_dp = 8'h0;
      exp_seg = 8'hFF; exp_dig = 8'hFF; exp_fd = 1'b0;
    end else if (!en_in) begin
      t = 0; last_t = -1;
      exp_seg = 8'hFF; exp_dig = 8'hFF; exp_fd = 1'b0;
    end else begin
      if (t % FRAME == 0) begin
        m_bcd = bcd_in;
        m_dp  = dp_in;
      end
      d      = (t / DIV) % N;
      exp_fd = (t % FRAME == FRAME - 1);
      if (t % DIV < BLANK) begin
        exp_seg = 8'hFF;
        exp_dig = 8'hFF;
      end else begin
        nib     = m_bcd[4*d +: 4];
        lead    = lz_en_in && (d != 0) && ((m_bcd >> (4*d)) == 32'h0);
        exp_seg = ~{m_dp[d], (lead ? 7'h00 : glyph_tab[nib])};
        exp_dig = ~(8'h01 << d);
      end
      last_t = t;
      t++;
    end
  end

  task automatic test_reset();
    rst = 1'b0; en_in = 1'b1;
    #1;
    checks++; if (dig_out !== 8'hFF) begin errors++; $display("FAIL reset_dig_async got %h want ff", dig_out); end
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg_async got %h want ff", seg_out); end
    repeat (3) @(negedge clk);
    checks++; if (dig_out !== 8'hFF) begin errors++; $display("FAIL reset_dig got %h want ff", dig_out); end
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg_out); end
    checks++; if (frame_done_out !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done_out); end
  endtask

  task automatic test_basic_scan();
    int fd_count = 0;
    bcd_in = 32'h76543210; dp_in = 8'h00; lz_en_in = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (frame_done_out === 1'b1) fd_count++;
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL basic_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL basic_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      checks++; if (frame_done_out !== exp_fd) begin errors++; $display("FAIL basic_fd t=%0d got %b want %b", last_t, frame_done_out, exp_fd); end
      if (last_t == 1) begin
        checks++; if (dig_out !== 8'hFF) begin errors++; $display("FAIL basic_blank got %h want ff", dig_out); end
      end
      if (last_t == 2) begin
        checks++; if ({dig_out, seg_out} !== 16'hFEC0) begin errors++; $display("FAIL basic_slot0 got %h%h want fec0", dig_out, seg_out); end
      end
      if (last_t == 12) begin
        checks++; if ({dig_out, seg_out} !== 16'hFDF9) begin errors++; $display("FAIL basic_slot1 got %h%h want fdf9", dig_out, seg_out); end
      end
    end
    checks++; if (fd_count !== 2) begin errors++; $display("FAIL basic_fd_count got %0d want 2", fd_count); end
  endtask

  task automatic test_snapshot();
    int t0 = t;
    for (int k = 0; k < 3 * FRAME && last_t < t0 + 2 * FRAME - 1; k++) begin
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL snap_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL snap_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      checks++; if (frame_done_out !== exp_fd) begin errors++; $display("FAIL snap_fd t=%0d got %b want %b", last_t, frame_done_out, exp_fd); end
      if (last_t == t0 + 34) bcd_in = 32'h99999999;
      if (last_t == t0 + 55) begin
        checks++; if ({dig_out, seg_out} !== 16'hDF92) begin errors++; $display("FAIL snap_old_d5 got %h%h want df92", dig_out, seg_out); end
      end
      if (last_t == t0 + FRAME + 5) begin
        checks++; if ({dig_out, seg_out} !== 16'hFE90) begin errors++; $display("FAIL snap_new_d0 got %h%h want fe90", dig_out, seg_out); end
      end
      if (last_t == t0 + FRAME + 75) begin
        checks++; if ({dig_out, seg_out} !== 16'h7F90) begin errors++; $display("FAIL snap_new_d7 got %h%h want 7f90", dig_out, seg_out); end
      end
    end
  endtask

  task automatic test_leading_zero();
    int t0 = t;
    bcd_in = 32'h00000105; lz_en_in = 1'b1; dp_in = 8'h04;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL lz_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL lz_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      if (last_t == t0 + FRAME - 1) bcd_in = 32'h0;
      if (last_t == t0 + 75) begin
        checks++; if ({dig_out, seg_out} !== 16'h7FFF) begin errors++; $display("FAIL lz_d7 got %h%h want 7fff", dig_out, seg_out); end
      end
      if (last_t == t0 + 35) begin
        checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL lz_d3 got %h want ff", seg_out); end
      end
      if (last_t == t0 + 25) begin
        checks++; if (seg_out !== 8'h79) begin errors++; $display("FAIL lz_d2 got %h want 79", seg_out); end
      end
      if (last_t == t0 + 15) begin
        checks++; if (seg_out !== 8'hC0) begin errors++; $display("FAIL lz_d1 got %h want c0", seg_out); end
      end
      if (last_t == t0 + 5) begin
        checks++; if (seg_out !== 8'h92) begin errors++; $display("FAIL lz_d0 got %h want 92", seg_out); end
      end
      if (last_t == t0 + FRAME + 5) begin
        checks++; if (seg_out !== 8'hC0) begin errors++; $display("FAIL lz_zero_d0 got %h want c0", seg_out); end
      end
      if (last_t == t0 + FRAME + 25) begin
        checks++; if ({dig_out, seg_out} !== 16'hFB7F) begin errors++; $display("FAIL lz_zero_d2dp got %h%h want fb7f", dig_out, seg_out); end
      end
    end
  endtask

  task automatic test_hex_enable();
    int t0 = t;
    bcd_in = 32'hFEDCBA98; lz_en_in = 1'b0; dp_in = 8'h00;
    for (int k = 0; k < FRAME && last_t < t0 + 53; k++) begin
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL hex_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL hex_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      if (last_t == t0 + 5) begin
        checks++; if (seg_out !== 8'h80) begin errors++; $display("FAIL hex_d0 got %h want 80", seg_out); end
      end
      if (last_t == t0 + 45) begin
        checks++; if ({dig_out, seg_out} !== 16'hEFC6) begin errors++; $display("FAIL hex_d4 got %h%h want efc6", dig_out, seg_out); end
      end
    end
    en_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if ({dig_out, seg_out, frame_done_out} !== {8'hFF, 8'hFF, 1'b0}) begin
        errors++; $display("FAIL hex_dark got %h %h %b want ff ff 0", dig_out, seg_out, frame_done_out);
      end
    end
    en_in = 1'b1;
    for (int k = 0; k < 2 * FRAME && last_t < FRAME - 2; k++) begin
      @(negedge clk);
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL hex_run_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
    end
    en_in = 1'b0;
    @(negedge clk);
    checks++; if (frame_done_out !== 1'b0) begin errors++; $display("FAIL hex_wrap_fd got %b want 0", frame_done_out); end
    bcd_in = 32'h00000007;
    en_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL hex_re_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      if (last_t == 2) begin
        checks++; if ({dig_out, seg_out} !== 16'hFEF8) begin errors++; $display("FAIL hex_restart got %h%h want fef8", dig_out, seg_out); end
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    for (int k = 0; k < 2 * FRAME && (last_t % FRAME) != 36; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({dig_out, seg_out, frame_done_out} !== {8'hFF, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL rst_mid got %h %h %b want ff ff 0", dig_out, seg_out, frame_done_out);
    end
    bcd_in = 32'h00000003;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL rst_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL rst_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      if (last_t == 1) begin
        checks++; if (dig_out !== 8'hFF) begin errors++; $display("FAIL rst_blank got %h want ff", dig_out); end
      end
      if (last_t == 2) begin
        checks++; if ({dig_out, seg_out} !== 16'hFEB0) begin errors++; $display("FAIL rst_first got %h%h want feb0", dig_out, seg_out); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10 * FRAME; k++) begin
      if (t % FRAME == 0) begin
        int z = $urandom_range(0, 8);
        bcd_in = (z == 8) ? 32'h0 : ($urandom() & (32'hFFFFFFFF >> (4 * z)));
        dp_in  = 8'($urandom());
      end else if ($urandom_range(0, 15) == 0) begin
        bcd_in = $urandom();
        dp_in  = 8'($urandom());
      end
      if ($urandom_range(0, 31) == 0) lz_en_in = 1'($urandom());
      @(negedge clk);
      checks++; if (dig_out !== exp_dig) begin errors++; $display("FAIL rand_dig t=%0d got %h want %h", last_t, dig_out, exp_dig); end
      checks++; if (seg_out !== exp_seg) begin errors++; $display("FAIL rand_seg t=%0d got %h want %h", last_t, seg_out, exp_seg); end
      checks++; if (frame_done_out !== exp_fd) begin errors++; $display("FAIL rand_fd t=%0d got %b want %b", last_t, frame_done_out, exp_fd); end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic_scan();
    test_snapshot();
    test_leading_zero();
    test_hex_enable();
    test_reset_mid_slot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Multiplexed 7-segment display driver. It consumes an 8-digit packed BCD/hex bus, such as the output of the scrolling-ID block, and time-multiplexes it onto a common segment bus with per-digit enables. It sits between the display-content generators and the board's 7-segment pins. Features: frame snapshot (no tearing), inter-digit blanking (anti-ghosting), leading-zero suppression, and a per-frame done pulse.

Parameters:
FREQUENCY_IN, 50_000_000, input clock frequency in Hz.
SCAN_FREQ, 1000, digit slot rate in Hz; DIV = FREQUENCY_IN/SCAN_FREQ clocks per slot; DIV >= 2 required.
DIGIT_NUM, 8, number of digits; bcd_in width = DIGIT_NUM*4.
BLANK_CYCLES, 16, clocks at the start of each slot with all digits off; must be < DIV.
SEG_ACTIVE_LOW, 1, 1 = seg_out inverted at the pins.
DIG_ACTIVE_LOW, 1, 1 = dig_out inverted at the pins.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
en_in  in  1  1 = scan, 0 = display dark and scan held.
bcd_in  in  DIGIT_NUM*4  digit i = bcd_in[4i+3:4i]; digit 0 is rightmost.
dp_in  in  DIGIT_NUM  decimal point per digit, 1 = lit.
lz_en_in  in  1  1 = suppress leading zeros.
seg_out  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
dig_out  out  DIGIT_NUM  one-hot digit enable, polarity per DIG_ACTIVE_LOW.
frame_done_out  out  1  one-clock pulse at end of each full frame.

Behaviour:
- State: slot counter cnt (0..DIV-1), digit index idx (0..DIGIT_NUM-1), shadow registers sh_bcd and sh_dp.
- Reset (rst=0, asynchronous):
  - cnt=0, idx=0, sh_bcd=0, sh_dp=0.
  - dig_out all inactive, seg_out all inactive (polarity applied), frame_done_out=0.
- en_in=0:
  - cnt and idx are forced to 0.
  - dig_out and seg_out go inactive on the next clock.
  - frame_done_out=0.
- Counting (en_in=1): cnt increments each clock. At cnt==DIV-1:
  - cnt wraps to 0.
  - idx increments, wrapping DIGIT_NUM-1 -> 0.
  - On that wrap, frame_done_out=1 for exactly that one clock.
- Snapshot: sh_bcd<=bcd_in and sh_dp<=dp_in on any clock with en_in=1, idx==0 and cnt==0. Covers the first clock after reset, after re-enable, and every frame start. Input changes mid-frame are not visible until the next frame.
- Output registers, updated every clock from the current (idx, cnt):
  - Blank window: if cnt < BLANK_CYCLES, all digits inactive and segments inactive.
  - Otherwise dig_out asserts only bit idx, and seg_out = {sh_dp[idx], glyph(sh_bcd digit idx)}.
  - Latency: 1 clock from counter state to pins.
- Glyphs, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero suppression: applies when lz_en_in=1, i != 0, and sh_bcd digits DIGIT_NUM-1 down to i are all 0.
  - The glyph field (bits 6:0) is inactive.
  - The dp bit still follows sh_dp[i].
  - dig_out still asserts in the slot.
  - Digit 0 is never suppressed.
- Polarity is applied as the final XOR on the output registers; the reset value is the inactive level after polarity.
- Simultaneous events:
  - en_in falling on the frame-wrap clock: the en_in=0 path wins and frame_done_out=0.
  - Reset mid-slot: immediate dark outputs; the scan restarts from digit 0 with a fresh snapshot.

Test Plan (FREQUENCY_IN=1000, SCAN_FREQ=100 -> DIV=10, BLANK_CYCLES=2, DIGIT_NUM=8, both ACTIVE_LOW=1):
1. Reset and idle: hold rst=0 -> dig_out=FF, seg_out=FF, frame_done_out=0, including asynchronously mid-clock.
2. Basic scan: bcd_in=32'h76543210, dp_in=0, lz_en_in=0, release reset.
   - Each 10-clock slot shows 2 clocks dig_out=FF, then 8 clocks of the digit enable.
   - Slot 0: dig_out=FE, seg_out=~8'h3F=C0.
   - Slot 1: dig_out=FD, seg_out=~06=F9.
   - frame_done_out pulses once every 80 clocks.
3. Snapshot: change bcd_in to 32'h99999999 during slot 3 -> slots 4..7 still show 4..7; the next frame shows 9 (seg_out=90) on all digits.
4. Leading zeros: bcd_in=32'h00000105, lz_en_in=1, dp_in=8'h04.
   - Digits 7..3: seg_out=FF.
   - Digit 2: seg_out=~(80|06)=79.
   - Digit 1: shows 0 (C0).
   - Digit 0: shows 5 (92).
   - With bcd_in=0: digit 0 still shows C0.
5. Hex and enable: bcd_in=32'hFEDCBA98.
   - Glyphs 7F, 6F, 77, 7C, 39, 5E, 79, 71 (inverted at pins).
   - Drop en_in during slot 5 -> outputs FF next clock, no frame_done.
   - Restore en_in -> restart at digit 0 with a fresh snapshot.
6. Reset mid-slot: assert rst in cnt=6 of slot 3 -> outputs FF immediately; after release, digit 0 is shown at clock 3 (blank window, then 1-clock latency).
